// File: rtl/execute_muldiv.sv
// MIPS execute stage: single-cycle ALU feeding a registered EX/MEM slot, plus an
// iterative radix-2 multiply/divide unit that owns HI/LO.
module execute_muldiv #(
  parameter logic [31:0] HILO_RESET = 32'h0,
  parameter bit          ENABLE_DIV = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [5:0]  opcode,
  input  logic [31:0] register_rs,
  input  logic [31:0] register_rt,
  input  logic [31:0] sign_extend,
  input  logic [4:0]  wreg_rd,
  input  logic [4:0]  wreg_rt,
  output logic        stall,
  output logic        result_valid,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic        regwrite_out,
  output logic [4:0]  wreg_address,
  output logic        md_busy
);
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, next_state;

  logic [5:0]    funct;
  logic [4:0]    shamt;
  logic [W-1:0]  imm_zx;
  logic [W-1:0]  alu_val;
  logic          alu_wr, is_r, is_hilo, is_md, md_div, md_signed;
  logic          accepted, md_start, md_step, md_finish;

  logic [W-1:0]  hi, lo;
  logic [CW-1:0] count;
  logic          op_div, op_signed;
  logic [W-1:0]  op_a, op_b, mag_b, acc_hi, acc_lo;
  logic [W-1:0]  mag_rs, mag_rt, step_hi, step_lo, fin_hi, fin_lo;
  logic [W:0]    add_sum, shifted, diff;
  logic [2*W-1:0] prod;
  logic          neg_q, neg_r;

  assign funct  = sign_extend[5:0];
  assign shamt  = sign_extend[10:6];
  assign imm_zx = {16'h0, sign_extend[15:0]};
  assign is_r   = (opcode == 6'h00);

  // Instruction decode and single-cycle ALU
  always_comb begin
    alu_val   = '0;
    alu_wr    = 1'b0;
    is_hilo   = 1'b0;
    is_md     = 1'b0;
    md_div    = 1'b0;
    md_signed = 1'b0;
    if (is_r) begin
      case (funct)
        6'h20, 6'h21: begin alu_val = register_rs + register_rt; alu_wr = 1'b1; end
        6'h22, 6'h23: begin alu_val = register_rs - register_rt; alu_wr = 1'b1; end
        6'h24: begin alu_val = register_rs & register_rt; alu_wr = 1'b1; end
        6'h25: begin alu_val = register_rs | register_rt; alu_wr = 1'b1; end
        6'h26: begin alu_val = register_rs ^ register_rt; alu_wr = 1'b1; end
        6'h27: begin alu_val = ~(register_rs | register_rt); alu_wr = 1'b1; end
        6'h2A: begin alu_val = W'($signed(register_rs) < $signed(register_rt)); alu_wr = 1'b1; end
        6'h2B: begin alu_val = W'(register_rs < register_rt); alu_wr = 1'b1; end
        6'h00: begin alu_val = register_rt << shamt; alu_wr = 1'b1; end
        6'h02: begin alu_val = register_rt >> shamt; alu_wr = 1'b1; end
        6'h03: begin alu_val = $signed(register_rt) >>> shamt; alu_wr = 1'b1; end
        6'h10: begin alu_val = hi; alu_wr = 1'b1; is_hilo = 1'b1; end
        6'h12: begin alu_val = lo; alu_wr = 1'b1; is_hilo = 1'b1; end
        6'h18: begin is_md = 1'b1; md_signed = 1'b1; end
        6'h19: is_md = 1'b1;
        6'h1A: begin is_md = ENABLE_DIV; md_div = 1'b1; md_signed = 1'b1; end
        6'h1B: begin is_md = ENABLE_DIV; md_div = 1'b1; end
        default: ;
      endcase
    end else begin
      case (opcode)
        6'h08, 6'h09: begin alu_val = register_rs + sign_extend; alu_wr = 1'b1; end
        6'h0A: begin alu_val = W'($signed(register_rs) < $signed(sign_extend)); alu_wr = 1'b1; end
        6'h0B: begin alu_val = W'(register_rs < sign_extend); alu_wr = 1'b1; end
        6'h0C: begin alu_val = register_rs & imm_zx; alu_wr = 1'b1; end
        6'h0D: begin alu_val = register_rs | imm_zx; alu_wr = 1'b1; end
        6'h0E: begin alu_val = register_rs ^ imm_zx; alu_wr = 1'b1; end
        6'h0F: begin alu_val = {sign_extend[15:0], 16'h0}; alu_wr = 1'b1; end
        6'h23: begin alu_val = register_rs + sign_extend; alu_wr = 1'b1; end
        6'h2B: alu_val = register_rs + sign_extend;
        6'h04, 6'h05: alu_val = register_rs - register_rt;
        default: ;
      endcase
    end
  end

  assign accepted = valid_in & ~stall;
  assign md_start = accepted & is_md;
  assign mag_rs   = (md_signed & register_rs[W-1]) ? -register_rs : register_rs;
  assign mag_rt   = (md_signed & register_rt[W-1]) ? -register_rt : register_rt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (md_start) next_state = BUSY;
      BUSY:    if (count == CW'(W - 1)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    md_step   = (state == BUSY);
    md_finish = (state == DONE);
    stall     = valid_in & (state != IDLE) & (is_md | is_hilo);
  end

  // One iteration on magnitudes: shift-add for multiply, restoring subtract for divide
  always_comb begin
    add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
    shifted = {acc_hi, acc_lo[W-1]};
    diff    = shifted - {1'b0, mag_b};
    if (op_div) begin
      if (shifted >= {1'b0, mag_b}) begin
        step_hi = diff[W-1:0];
        step_lo = {acc_lo[W-2:0], 1'b1};
      end else begin
        step_hi = shifted[W-1:0];
        step_lo = {acc_lo[W-2:0], 1'b0};
      end
    end else begin
      step_hi = add_sum[W:1];
      step_lo = {add_sum[0], acc_lo[W-1:1]};
    end
  end

  // Sign fix-up; remainder follows the dividend, divide-by-zero is special-cased
  always_comb begin
    neg_q = op_signed & (op_a[W-1] ^ op_b[W-1]);
    neg_r = op_signed & op_a[W-1];
    prod  = {acc_hi, acc_lo};
    fin_hi = acc_hi;
    fin_lo = acc_lo;
    if (!op_div) begin
      {fin_hi, fin_lo} = neg_q ? -prod : prod;
    end else if (op_b == '0) begin
      fin_lo = '1;
      fin_hi = op_a;
    end else begin
      fin_lo = neg_q ? -acc_lo : acc_lo;
      fin_hi = neg_r ? -acc_hi : acc_hi;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi           <= HILO_RESET;
      lo           <= HILO_RESET;
      count        <= '0;
      op_div       <= 1'b0;
      op_signed    <= 1'b0;
      op_a         <= '0;
      op_b         <= '0;
      mag_b        <= '0;
      acc_hi       <= '0;
      acc_lo       <= '0;
      md_busy      <= 1'b0;
      result_valid <= 1'b0;
      regwrite_out <= 1'b0;
      alu_result   <= '0;
      zero         <= 1'b0;
      wreg_address <= '0;
    end else begin
      md_busy <= (next_state != IDLE);
      if (md_start) begin
        count     <= '0;
        op_div    <= md_div;
        op_signed <= md_signed;
        op_a      <= register_rs;
        op_b      <= register_rt;
        mag_b     <= mag_rt;
        acc_hi    <= '0;
        acc_lo    <= mag_rs;
      end else if (md_step) begin
        count  <= count + CW'(1);
        acc_hi <= step_hi;
        acc_lo <= step_lo;
      end else if (md_finish) begin
        hi <= fin_hi;
        lo <= fin_lo;
      end
      result_valid <= accepted;
      regwrite_out <= accepted & alu_wr;
      if (accepted) begin
        alu_result   <= alu_val;
        zero         <= (alu_val == '0);
        wreg_address <= is_r ? wreg_rd : wreg_rt;
      end
    end
  end
endmodule

// File: tb/tb_execute_muldiv.sv
// Scoreboard bench for execute_muldiv: issued instructions push expected EX/MEM
// contents from an arithmetic reference model; a monitor pops on each result_valid.
module tb_execute_muldiv;
  localparam logic [31:0] HILO_RST = 32'hA5A5_0F0F;

  logic        clock, reset, valid_in;
  logic [5:0]  opcode;
  logic [31:0] register_rs, register_rt, sign_extend;
  logic [4:0]  wreg_rd, wreg_rt;
  logic        stall, result_valid, zero, regwrite_out, md_busy;
  logic [31:0] alu_result;
  logic [4:0]  wreg_address;

  execute_muldiv #(.HILO_RESET(HILO_RST), .ENABLE_DIV(1'b1)) dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .opcode(opcode),
    .register_rs(register_rs), .register_rt(register_rt), .sign_extend(sign_extend),
    .wreg_rd(wreg_rd), .wreg_rt(wreg_rt), .stall(stall), .result_valid(result_valid),
    .alu_result(alu_result), .zero(zero), .regwrite_out(regwrite_out),
    .wreg_address(wreg_address), .md_busy(md_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] res;
    logic        zf;
    logic        wr;
    logic [4:0]  addr;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_hi = HILO_RST;
  logic [31:0] m_lo = HILO_RST;

  logic [5:0] functs [20] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                              6'h2B, 6'h00, 6'h02, 6'h03, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1A,
                              6'h1B, 6'h3F};
  logic [5:0] iops [13] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23,
                            6'h2B, 6'h04, 6'h05, 6'h3F};

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: instruction semantics in plain integer arithmetic
  task automatic model(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] se, input logic [4:0] rd, input logic [4:0] rta,
                       output exp_t e);
    logic [31:0] r;
    logic        wr;
    int          sa, a_s, b_s;
    longint      ps;
    logic [63:0] pu;
    r = 0; wr = 0; sa = int'(se[10:6]); a_s = rs; b_s = rt;
    if (op == 6'h00) begin
      case (se[5:0])
        6'h20, 6'h21: begin r = rs + rt; wr = 1; end
        6'h22, 6'h23: begin r = rs - rt; wr = 1; end
        6'h24: begin r = rs & rt; wr = 1; end
        6'h25: begin r = rs | rt; wr = 1; end
        6'h26: begin r = rs ^ rt; wr = 1; end
        6'h27: begin r = ~(rs | rt); wr = 1; end
        6'h2A: begin r = (a_s < b_s) ? 32'd1 : 32'd0; wr = 1; end
        6'h2B: begin r = (rs < rt) ? 32'd1 : 32'd0; wr = 1; end
        6'h00: begin r = rt << sa; wr = 1; end
        6'h02: begin r = rt >> sa; wr = 1; end
        6'h03: begin r = 32'(b_s >>> sa); wr = 1; end
        6'h10: begin r = m_hi; wr = 1; end
        6'h12: begin r = m_lo; wr = 1; end
        6'h18: begin ps = longint'(a_s) * longint'(b_s); {m_hi, m_lo} = ps; end
        6'h19: begin pu = 64'(rs) * 64'(rt); {m_hi, m_lo} = pu; end
        6'h1A: begin
          if (rt == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = rs; end
          else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin m_lo = rs; m_hi = 0; end
          else begin m_lo = 32'(a_s / b_s); m_hi = 32'(a_s % b_s); end
        end
        6'h1B: begin
          if (rt == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = rs; end
          else begin m_lo = rs / rt; m_hi = rs % rt; end
        end
        default: ;
      endcase
    end else begin
      case (op)
        6'h08, 6'h09: begin r = rs + se; wr = 1; end
        6'h0A: begin r = ($signed(rs) < $signed(se)) ? 32'd1 : 32'd0; wr = 1; end
        6'h0B: begin r = (rs < se) ? 32'd1 : 32'd0; wr = 1; end
        6'h0C: begin r = rs & {16'h0, se[15:0]}; wr = 1; end
        6'h0D: begin r = rs | {16'h0, se[15:0]}; wr = 1; end
        6'h0E: begin r = rs ^ {16'h0, se[15:0]}; wr = 1; end
        6'h0F: begin r = {se[15:0], 16'h0}; wr = 1; end
        6'h23: begin r = rs + se; wr = 1; end
        6'h2B: r = rs + se;
        6'h04, 6'h05: r = rs - rt;
        default: ;
      endcase
    end
    e.res = r; e.zf = (r == 0); e.wr = wr; e.addr = (op == 6'h00) ? rd : rta;
  endtask

  // Present one instruction, wait out any stall, record its expected retirement
  task automatic issue(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] se, output int stalls);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clock);
    valid_in = 1; opcode = op; register_rs = rs; register_rt = rt; sign_extend = se;
    wreg_rd = 5'($urandom_range(1, 31)); wreg_rt = 5'($urandom_range(1, 31));
    #1;
    while (stall && n < 200) begin n++; @(negedge clock); #1; end
    if (stall) check32("stall_timeout", {31'b0, stall}, 32'h0);
    else begin
      model(op, rs, rt, se, wreg_rd, wreg_rt, e);
      exp_q.push_back(e);
    end
    stalls = n;
    @(posedge clock);
    #1 valid_in = 0;
  endtask

  task automatic rtype(input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [4:0] sh, output int stalls);
    issue(6'h00, rs, rt, {16'h0, 5'h0, sh, fn}, stalls);
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset && result_valid) begin
      if (exp_q.size() == 0) check32("orphan_result", {31'b0, result_valid}, 32'h0);
      else begin
        e = exp_q.pop_front();
        check32("alu_result", alu_result, e.res);
        check32("zero", {31'b0, zero}, {31'b0, e.zf});
        check32("regwrite_out", {31'b0, regwrite_out}, {31'b0, e.wr});
        check32("wreg_address", {27'b0, wreg_address}, {27'b0, e.addr});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          s, k;
    logic [31:0] a, b;
    logic [15:0] imm;
    reset = 0; valid_in = 0; opcode = 0; register_rs = 0; register_rt = 0;
    sign_extend = 0; wreg_rd = 0; wreg_rt = 0;
    repeat (2) @(negedge clock);
    check32("rst_result_valid", {31'b0, result_valid}, 32'h0);
    check32("rst_alu_result", alu_result, 32'h0);
    check32("rst_zero", {31'b0, zero}, 32'h0);
    check32("rst_regwrite", {31'b0, regwrite_out}, 32'h0);
    check32("rst_wreg", {27'b0, wreg_address}, 32'h0);
    check32("rst_md_busy", {31'b0, md_busy}, 32'h0);
    @(negedge clock) reset = 1;

    rtype(6'h10, 0, 0, 0, s);
    rtype(6'h12, 0, 0, 0, s);
    issue(6'h08, 32'd5, 32'd0, 32'hFFFF_FFFF, s);
    rtype(6'h22, 32'd7, 32'd7, 0, s);
    rtype(6'h2A, 32'hFFFF_FFFF, 32'd1, 0, s);
    rtype(6'h2B, 32'hFFFF_FFFF, 32'd1, 0, s);
    rtype(6'h03, 0, 32'h8000_0000, 5'd4, s);
    issue(6'h0F, 0, 0, 32'hFFFF_8001, s);

    rtype(6'h18, 32'hFFFF_FFFD, 32'd5, 0, s);
    rtype(6'h12, 0, 0, 0, s);
    check32("mult_mflo_stall_cycles", 32'(s), 32'd33);
    rtype(6'h10, 0, 0, 0, s);
    rtype(6'h1A, 32'hFFFF_FFF9, 32'd2, 0, s);
    rtype(6'h12, 0, 0, 0, s);
    rtype(6'h10, 0, 0, 0, s);
    rtype(6'h1B, 32'd9, 32'd0, 0, s);
    rtype(6'h12, 0, 0, 0, s);
    rtype(6'h10, 0, 0, 0, s);
    rtype(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 0, s);
    rtype(6'h12, 0, 0, 0, s);
    rtype(6'h10, 0, 0, 0, s);

    rtype(6'h18, rnd_op(), rnd_op(), 0, s);
    rtype(6'h20, 32'd1, 32'd2, 0, s);
    check32("alu_while_busy_stalls", 32'(s), 32'd0);
    check32("md_busy_high", {31'b0, md_busy}, 32'h1);
    rtype(6'h19, rnd_op(), rnd_op(), 0, s);
    check32("mult_while_busy_stalls", 32'(s), 32'd32);
    rtype(6'h12, 0, 0, 0, s);
    rtype(6'h10, 0, 0, 0, s);

    rtype(6'h19, 32'h1234_5678, 32'h9ABC_DEF0, 0, s);
    rtype(6'h20, 32'd1, 32'd2, 0, s);
    repeat (9) @(posedge clock);
    @(negedge clock); #1;
    check32("bubble_result_valid", {31'b0, result_valid}, 32'h0);
    check32("bubble_regwrite", {31'b0, regwrite_out}, 32'h0);
    check32("hold_alu_result", alu_result, 32'd3);
    check32("busy_before_reset", {31'b0, md_busy}, 32'h1);
    reset = 0; #1;
    check32("midrst_md_busy", {31'b0, md_busy}, 32'h0);
    check32("midrst_alu_result", alu_result, 32'h0);
    check32("midrst_wreg", {27'b0, wreg_address}, 32'h0);
    @(negedge clock) reset = 1;
    m_hi = HILO_RST; m_lo = HILO_RST;
    rtype(6'h10, 0, 0, 0, s);
    check32("post_reset_mfhi_stalls", 32'(s), 32'd0);
    rtype(6'h12, 0, 0, 0, s);

    for (int i = 0; i < 250; i++) begin
      k = $urandom_range(0, 32);
      a = rnd_op(); b = rnd_op(); imm = 16'($urandom);
      if (k < 20) begin
        imm[5:0] = functs[k];
        issue(6'h00, a, b, {{16{imm[15]}}, imm}, s);
      end else begin
        issue(iops[k-20], a, b, {{16{imm[15]}}, imm}, s);
      end
    end
    rtype(6'h12, 0, 0, 0, s);
    rtype(6'h10, 0, 0, 0, s);

    repeat (3) @(negedge clock);
    check32("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
